decode_packet_sender: RTL and testbench

- Producer side of the instruction-buffer write interface. Sits between the decode stage and the instruction buffer.
- Accepts decoded bundles of up to 2*FETCH_BANDWIDTH micro-op slots and left-compacts each bundle's valid slots into contiguous low slots.
- Holds bundles in a small FIFO and presents them to the buffer with decodeReady/decodedVector/decodedPacket.
- Re-presents the same bundle every cycle the buffer asserts stallFetch, because the buffer drops writes while stalled.

---
 rtl/decode_packet_sender.sv | 83 ++++++++
 tb/tb_decode_packet_sender.sv | 131 +++++++++++++
 2 files changed

// File: rtl/decode_packet_sender.sv
// decode_packet_sender: left-compacts decoded bundles into a small FIFO and presents the head bundle to the instruction buffer
// Ports: clk/reset (sync, active-high); flush_i clears queued bundles but keeps stall_cycles_o;
//   bundle_valid_i/bundle_vector_i/bundle_packets_i/bundle_ready_o form the upstream handshake;
//   stallFetch_i holds the head bundle; decodeReady_o/decodedVector_o/decodedPackets_o present it;
//   occupancy_o is the bundle count; stall_cycles_o is a saturating count of stalled presentations.
module decode_packet_sender #(
  parameter int FETCH_BANDWIDTH = 4,
  parameter int PKT_W = 100,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic bundle_valid_i,
  input  logic [2*FETCH_BANDWIDTH-1:0] bundle_vector_i,
  input  logic [2*FETCH_BANDWIDTH*PKT_W-1:0] bundle_packets_i,
  output logic bundle_ready_o,
  input  logic stallFetch_i,
  output logic decodeReady_o,
  output logic [2*FETCH_BANDWIDTH-1:0] decodedVector_o,
  output logic [2*FETCH_BANDWIDTH*PKT_W-1:0] decodedPackets_o,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic [15:0] stall_cycles_o
);
  localparam int NSLOT = 2*FETCH_BANDWIDTH;
  localparam int CW = $clog2(NSLOT)+1;
  localparam int PW = $clog2(DEPTH);
  logic [NSLOT*PKT_W-1:0] entPk [DEPTH];
  logic [CW-1:0] entCnt [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [PW:0] count;
  logic [NSLOT*PKT_W-1:0] compPk;
  logic [CW-1:0] compCnt;
  logic push, store, transfer;
  // Running index of the next free output slot; its final value is the popcount.
  always_comb begin
    compPk = '0;
    compCnt = '0;
    for (int k = 0; k < NSLOT; k++) begin
      if (bundle_vector_i[k]) begin
        compPk[int'(compCnt)*PKT_W +: PKT_W] = bundle_packets_i[k*PKT_W +: PKT_W];
        compCnt = compCnt + 1'b1;
      end
    end
  end
  assign bundle_ready_o = count < (PW+1)'(DEPTH);
  assign push = bundle_valid_i & bundle_ready_o & ~flush_i & ~reset;
  // An all-empty bundle completes the handshake but never occupies an entry.
  assign store = push & (|bundle_vector_i);
  assign decodeReady_o = count != '0;
  assign transfer = decodeReady_o & ~stallFetch_i;
  assign decodedPackets_o = decodeReady_o ? entPk[rdPtr] : '0;
  assign occupancy_o = count;
  always_comb begin
    decodedVector_o = '0;
    for (int j = 0; j < NSLOT; j++) decodedVector_o[j] = decodeReady_o && (j < int'(entCnt[rdPtr]));
  end
  always_ff @(posedge clk) begin
    if (store) begin
      entPk[wrPtr] <= compPk;
      entCnt[wrPtr] <= compCnt;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (decodeReady_o & stallFetch_i & ~flush_i & ~&stall_cycles_o) stall_cycles_o <= stall_cycles_o + 16'd1;
      if (flush_i) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        rdPtr <= rdPtr + PW'(transfer);
        wrPtr <= wrPtr + PW'(store);
        count <= count + (PW+1)'(store) - (PW+1)'(transfer);
      end
    end
  end
endmodule

// File: tb/tb_decode_packet_sender.sv
// tb_decode_packet_sender: randomized and directed checks of decode_packet_sender against a queue-based reference model
module tb_decode_packet_sender;
  localparam int NSLOT = 8;
  localparam int PKT_W = 100;
  localparam int DEPTH = 2;
  localparam int TW = NSLOT*PKT_W;
  typedef struct {logic [TW-1:0] pk; int n;} ent_t;
  logic clk = 0, reset = 1, flush_i = 0, bundle_valid_i = 0, stallFetch_i = 0;
  logic [NSLOT-1:0] bundle_vector_i = '0;
  logic [TW-1:0] bundle_packets_i = '0;
  logic bundle_ready_o, decodeReady_o;
  logic [NSLOT-1:0] decodedVector_o;
  logic [TW-1:0] decodedPackets_o;
  logic [1:0] occupancy_o;
  logic [15:0] stall_cycles_o;
  int errors = 0, checks = 0, sc = 0;
  ent_t q[$];
  decode_packet_sender #(.FETCH_BANDWIDTH(4), .PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .bundle_valid_i(bundle_valid_i),
    .bundle_vector_i(bundle_vector_i), .bundle_packets_i(bundle_packets_i),
    .bundle_ready_o(bundle_ready_o), .stallFetch_i(stallFetch_i), .decodeReady_o(decodeReady_o),
    .decodedVector_o(decodedVector_o), .decodedPackets_o(decodedPackets_o),
    .occupancy_o(occupancy_o), .stall_cycles_o(stall_cycles_o));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic ent_t compact(input logic [NSLOT-1:0] v, input logic [TW-1:0] p);
    logic [PKT_W-1:0] sel[$];
    ent_t e;
    e.pk = '0;
    for (int k = 0; k < NSLOT; k++) if (v[k]) sel.push_back(p[k*PKT_W +: PKT_W]);
    foreach (sel[j]) e.pk[j*PKT_W +: PKT_W] = sel[j];
    e.n = sel.size();
    return e;
  endfunction
  function automatic logic [TW-1:0] randPk();
    logic [TW-1:0] r;
    for (int i = 0; i < TW; i++) r[i] = 1'($urandom);
    return r;
  endfunction
  task automatic checkOutputs();
    check("occ", occupancy_o, q.size());
    check("brdy", bundle_ready_o, q.size() < DEPTH);
    check("drdy", decodeReady_o, q.size() != 0);
    check("vec", decodedVector_o, q.size() != 0 ? (1 << q[0].n) - 1 : 0);
    check("pk", decodedPackets_o, q.size() != 0 ? q[0].pk : '0);
    check("stall", stall_cycles_o, sc);
  endtask
  task automatic cycle(input logic r, input logic f, input logic v, input logic [NSLOT-1:0] vec,
                       input logic [TW-1:0] pk, input logic st);
    bit push, xfer;
    @(negedge clk);
    reset = r; flush_i = f; bundle_valid_i = v; bundle_vector_i = vec; bundle_packets_i = pk; stallFetch_i = st;
    push = v && q.size() < DEPTH && !f && !r;
    xfer = q.size() != 0 && !st;
    @(posedge clk);
    if (r) begin
      q.delete();
      sc = 0;
    end else begin
      if (q.size() != 0 && st && !f && sc < 'hFFFF) sc++;
      if (f) q.delete();
      else begin
        if (xfer) q.delete(0);
        if (push && vec != 0) q.push_back(compact(vec, pk));
      end
    end
    #1 checkOutputs();
  endtask
  initial begin
    logic [TW-1:0] p, e;
    p = '0;
    for (int k = 0; k < NSLOT; k++) p[k*PKT_W +: PKT_W] = PKT_W'('hA0 + k);
    cycle(1, 0, 0, '0, '0, 0);
    cycle(1, 0, 0, '0, '0, 0);
    cycle(0, 0, 1, 8'b1010_0101, p, 0);
    e = '0;
    e[0 +: PKT_W] = PKT_W'('hA0);
    e[PKT_W +: PKT_W] = PKT_W'('hA2);
    e[2*PKT_W +: PKT_W] = PKT_W'('hA5);
    e[3*PKT_W +: PKT_W] = PKT_W'('hA7);
    check("cmp_vec", decodedVector_o, 8'h0F);
    check("cmp_pk", decodedPackets_o, e);
    cycle(0, 0, 0, '0, '0, 0);
    check("cmp_after", decodeReady_o, 0);
    cycle(1, 0, 0, '0, '0, 0);
    cycle(0, 0, 1, 8'h81, randPk(), 1);
    repeat (3) cycle(0, 0, 0, '0, '0, 1);
    cycle(0, 0, 0, '0, '0, 0);
    check("stall3", stall_cycles_o, 3);
    cycle(0, 0, 1, 8'h0F, randPk(), 1);
    cycle(0, 0, 1, 8'hF0, randPk(), 1);
    check("full_brdy", bundle_ready_o, 0);
    cycle(0, 0, 1, 8'hFF, randPk(), 1);
    repeat (3) cycle(0, 0, 0, '0, '0, 0);
    cycle(0, 0, 1, 8'h3C, randPk(), 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, NSLOT'($urandom_range(1, 255)), randPk(), 0);
    check("b2b_occ", occupancy_o, 1);
    repeat (2) cycle(0, 0, 0, '0, '0, 0);
    cycle(0, 0, 1, '0, randPk(), 0);
    check("empty_occ", occupancy_o, 0);
    cycle(1, 0, 0, '0, '0, 0);
    cycle(0, 0, 1, 8'h01, randPk(), 1);
    cycle(0, 0, 1, 8'h02, randPk(), 1);
    repeat (4) cycle(0, 0, 0, '0, '0, 1);
    cycle(0, 1, 1, 8'hFF, randPk(), 0);
    check("fl_sc", stall_cycles_o, 5);
    check("fl_occ", occupancy_o, 0);
    cycle(0, 0, 0, '0, '0, 0);
    cycle(1, 1, 1, 8'hFF, randPk(), 0);
    check("rst_sc", stall_cycles_o, 0);
    for (int i = 0; i < 600; i++) begin
      logic r, f, st;
      logic [NSLOT-1:0] vec;
      int m;
      r = ($urandom % 100) == 0;
      f = ($urandom % 30) == 0;
      st = f ? 1'b0 : 1'($urandom);
      m = $urandom % 4;
      vec = m == 0 ? '0 : m == 1 ? '1 : NSLOT'($urandom);
      cycle(r, f, ($urandom % 10) < 7, vec, randPk(), st);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
